// File: rtl/macc_accumulator_if.sv
// Product-in / result-out handshake bundle for the MACC accumulation stage,
// plus the per-window configuration and status signals that travel with it.
interface macc_accumulator_if #(
  parameter int PROD_W = 15,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
);
  logic        [LEN_W-1:0]  cfg_len;
  logic signed [ACC_W-1:0]  cfg_bias;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic                     out_sat;
  logic                     busy;

  modport master (
    output cfg_len, cfg_bias, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_acc, out_sat, busy
  );

  modport slave (
    input  cfg_len, cfg_bias, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_acc, out_sat, busy
  );
endinterface

// File: rtl/macc_accumulator.sv
// Windowed saturating accumulator: sums cfg_len signed products plus a bias
// and emits one clamped result per window through a registered valid/ready port.
module macc_accumulator #(
  parameter int PROD_W = 15,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  macc_accumulator_if.slave bus
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                  r_state,     w_state_nxt;
  logic signed [ACC_W-1:0] r_acc,       w_acc_nxt;
  logic [LEN_W-1:0]        r_cnt,       w_cnt_nxt;
  logic [LEN_W-1:0]        r_len_q,     w_len_nxt;
  logic                    r_sat_q,     w_sat_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic signed [ACC_W-1:0] r_out_acc,   w_out_acc_nxt;
  logic                    r_out_sat,   w_out_sat_nxt;

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_first;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_clamp;
  logic signed [ACC_W-1:0] w_clamped;
  logic [LEN_W-1:0]        w_len_eff;
  logic [LEN_W:0]          w_cnt_inc;
  logic                    w_done;

  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_first    = (r_state == S_IDLE);

  // The first beat of a window starts from the bias instead of the running sum.
  assign w_base    = w_first ? bus.cfg_bias : r_acc;
  assign w_sum     = {w_base[ACC_W-1], w_base}
                   + {{(ACC_W+1-PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
  assign w_clamp   = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_clamped = !w_clamp     ? w_sum[ACC_W-1:0] :
                     w_sum[ACC_W] ? ACC_MIN : ACC_MAX;

  assign w_len_eff = !w_first                 ? r_len_q  :
                     (bus.cfg_len == '0)      ? LEN_W'(1) : bus.cfg_len;
  assign w_cnt_inc = {1'b0, (w_first ? {LEN_W{1'b0}} : r_cnt)} + (LEN_W+1)'(1);
  assign w_done    = (w_cnt_inc == {1'b0, w_len_eff});

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len_q;
    w_sat_nxt       = r_sat_q;
    w_out_valid_nxt = r_out_valid;
    w_out_acc_nxt   = r_out_acc;
    w_out_sat_nxt   = r_out_sat;

    if (r_out_valid && bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_accept) begin
      w_sat_nxt = (~w_first & r_sat_q) | w_clamp;
      if (w_first) begin
        w_len_nxt = w_len_eff;
      end
      if (w_done) begin
        // A completion on the same edge as a drain simply reloads the result.
        w_state_nxt     = S_IDLE;
        w_cnt_nxt       = '0;
        w_out_valid_nxt = 1'b1;
        w_out_acc_nxt   = w_clamped;
        w_out_sat_nxt   = (~w_first & r_sat_q) | w_clamp;
      end else begin
        w_state_nxt = S_ACCUM;
        w_acc_nxt   = w_clamped;
        w_cnt_nxt   = w_cnt_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_sat_q     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len_q     <= w_len_nxt;
      r_sat_q     <= w_sat_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_acc   <= w_out_acc_nxt;
      r_out_sat   <= w_out_sat_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_sat   = r_out_sat;
  assign bus.busy      = (r_state == S_ACCUM);

endmodule

// File: tb/tb_macc_accumulator.sv
// Self-checking bench for macc_accumulator: directed scenarios plus a randomized
// stream checked against a window-level reference model.
module tb_macc_accumulator;

  localparam int PROD_W = 15;
  localparam int ACC_W  = 24;
  localparam int LEN_W  = 8;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic signed [ACC_W-1:0] exp_acc;

  macc_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  macc_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.cfg_len   = '0;
    bus.cfg_bias  = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_acc !== '0) begin n_fail++; $display("FAIL reset_out_acc: got %0d expected 0", bus.out_acc); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %0b expected 0", bus.out_sat); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic_sum();
    bus.cfg_len  = 9;
    bus.cfg_bias = 0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = PROD_W'(i);
      n_checks++; if (bus.busy !== (i > 1)) begin n_fail++; $display("FAIL basic_busy beat %0d: got %0b expected %0b", i, bus.busy, (i > 1)); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid beat %0d: got %0b expected 0", i, bus.out_valid); end
      tick();
    end
    bus.in_valid = 1'b0;
    exp_acc = 45;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_acc !== exp_acc) begin n_fail++; $display("FAIL basic_acc: got %0d expected %0d", bus.out_acc, exp_acc); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %0b expected 0", bus.out_sat); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %0b expected 0", bus.busy); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_bias_negative();
    int prods [3] = '{-16384, -1, 5};
    bus.cfg_len  = 3;
    bus.cfg_bias = 100;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = PROD_W'(prods[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    exp_acc = -16280;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bias_valid: got %0b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_acc !== exp_acc) begin n_fail++; $display("FAIL bias_acc: got %0d expected %0d", bus.out_acc, exp_acc); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL bias_sat: got %0b expected 0", bus.out_sat); end
    tick();
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.cfg_len = 2;   bus.cfg_bias = 8388592;  bus.in_prod = 16383;
    tick();
    bus.cfg_len = 200; bus.cfg_bias = 5;        bus.in_prod = -1;
    tick();
    exp_acc = 8388606;
    n_checks++; if (bus.out_acc !== exp_acc) begin n_fail++; $display("FAIL sat_max_acc: got %0d expected %0d", bus.out_acc, exp_acc); end
    n_checks++; if (bus.out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_max_flag: got %0b expected 1", bus.out_sat); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_max_valid: got %0b expected 1", bus.out_valid); end
    bus.cfg_len = 1;   bus.cfg_bias = 0;        bus.in_prod = 7;
    tick();
    exp_acc = 7;
    n_checks++; if (bus.out_acc !== exp_acc) begin n_fail++; $display("FAIL sat_next_acc: got %0d expected %0d", bus.out_acc, exp_acc); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL sat_next_flag: got %0b expected 0", bus.out_sat); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_next_valid: got %0b expected 1", bus.out_valid); end
    bus.cfg_len = 2;   bus.cfg_bias = -8388600; bus.in_prod = -16384;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_min_midwin_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sat_min_busy: got %0b expected 1", bus.busy); end
    bus.cfg_len = 9;   bus.cfg_bias = 1234;     bus.in_prod = 10;
    tick();
    bus.in_valid = 1'b0;
    exp_acc = -8388598;
    n_checks++; if (bus.out_acc !== exp_acc) begin n_fail++; $display("FAIL sat_min_acc: got %0d expected %0d", bus.out_acc, exp_acc); end
    n_checks++; if (bus.out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_min_flag: got %0b expected 1", bus.out_sat); end
    tick();
  endtask

  task automatic test_backpressure();
    int lens [2] = '{1, 0};
    for (int k = 0; k < 2; k++) begin
      bus.cfg_len   = LEN_W'(lens[k]);
      bus.cfg_bias  = 0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_prod   = 10;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_first len=%0d: got %0b expected 1", lens[k], bus.in_ready); end
      tick();
      bus.in_prod = 20;
      for (int c = 0; c < 4; c++) begin
        exp_acc = 10;
        n_checks++; if (bus.out_acc !== exp_acc || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold len=%0d: got %0d/%0b expected %0d/1", lens[k], bus.out_acc, bus.out_valid, exp_acc); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready len=%0d: got %0b expected 0", lens[k], bus.in_ready); end
        if (c < 3) tick();
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready len=%0d: got %0b expected 1", lens[k], bus.in_ready); end
      tick();
      exp_acc = 20;
      n_checks++; if (bus.out_acc !== exp_acc || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second len=%0d: got %0d/%0b expected %0d/1", lens[k], bus.out_acc, bus.out_valid, exp_acc); end
      bus.in_prod = 30;
      tick();
      exp_acc = 30;
      n_checks++; if (bus.out_acc !== exp_acc || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third len=%0d: got %0d/%0b expected %0d/1", lens[k], bus.out_acc, bus.out_valid, exp_acc); end
      bus.in_valid = 1'b0;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain len=%0d: got %0b expected 0", lens[k], bus.out_valid); end
    end
  endtask

  task automatic test_reset_mid_window();
    int prods [3] = '{1000, 2000, 3000};
    bus.cfg_len   = 4;
    bus.cfg_bias  = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = PROD_W'(prods[i]);
      tick();
    end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %0b expected 1", bus.busy); end
    rst = 1'b1;
    bus.in_prod = 500;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_acc !== '0) begin n_fail++; $display("FAIL rstmid_acc: got %0d expected 0", bus.out_acc); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL rstmid_sat: got %0b expected 0", bus.out_sat); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b expected 0", bus.busy); end
    bus.cfg_len = 2;
    bus.in_prod = 3;
    tick();
    bus.in_prod = 4;
    tick();
    bus.in_valid = 1'b0;
    exp_acc = 7;
    n_checks++; if (bus.out_acc !== exp_acc || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh: got %0d/%0b expected %0d/1", bus.out_acc, bus.out_valid, exp_acc); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL rstmid_fresh_sat: got %0b expected 0", bus.out_sat); end
    tick();
  endtask

  // Window-level reference: collect accepted products per window, then fold
  // them from the bias with clamping once the window is full.
  task automatic test_random_stream();
    bit     m_valid = 1'b0;
    longint m_acc   = 0;
    bit     m_sat   = 1'b0;
    int     m_len   = 0;
    longint m_bias  = 0;
    longint win_q [$];
    longint p, b, s;
    bit     exp_ready, sat;
    int     n_results = 0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.out_ready = ($urandom % 4) != 0;
      bus.in_valid  = ($urandom % 3) != 0;
      p = longint'($urandom_range(0, (1 << PROD_W) - 1)) - (longint'(1) << (PROD_W-1));
      bus.in_prod = PROD_W'(p);
      case ($urandom % 4)
        0:       b = ACC_MAX - longint'($urandom_range(0, 20000));
        1:       b = ACC_MIN + longint'($urandom_range(0, 20000));
        2:       b = longint'($urandom_range(0, (1 << ACC_W) - 1)) + ACC_MIN;
        default: b = longint'($urandom_range(0, 2000)) - 1000;
      endcase
      if (win_q.size() == 0) begin
        bus.cfg_len  = 3;
        bus.cfg_bias = ACC_W'(b);
      end else begin
        bus.cfg_len  = LEN_W'($urandom);
        bus.cfg_bias = ACC_W'($urandom);
      end
      #1;
      exp_ready = !m_valid || bus.out_ready;
      n_checks++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d: got %0b expected %0b", cyc, bus.in_ready, exp_ready); end
      n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d: got %0b expected %0b", cyc, bus.out_valid, m_valid); end
      n_checks++; if (bus.busy !== (win_q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %0b expected %0b", cyc, bus.busy, (win_q.size() != 0)); end
      if (m_valid) begin
        exp_acc = ACC_W'(m_acc);
        n_checks++; if (bus.out_acc !== exp_acc || bus.out_sat !== m_sat) begin n_fail++; $display("FAIL rnd_result cyc %0d: got %0d/%0b expected %0d/%0b", cyc, bus.out_acc, bus.out_sat, exp_acc, m_sat); end
      end

      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (bus.in_valid && exp_ready) begin
        if (win_q.size() == 0) begin
          m_len  = 3;
          m_bias = b;
        end
        win_q.push_back(p);
        if (win_q.size() == m_len) begin
          s = m_bias;
          sat = 1'b0;
          foreach (win_q[k]) begin
            s = s + win_q[k];
            if (s > ACC_MAX) begin s = ACC_MAX; sat = 1'b1; end
            else if (s < ACC_MIN) begin s = ACC_MIN; sat = 1'b1; end
          end
          m_acc   = s;
          m_sat   = sat;
          m_valid = 1'b1;
          win_q.delete();
          n_results++;
        end
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++; if (n_results < 50) begin n_fail++; $display("FAIL rnd_result_count: got %0d expected at least 50", n_results); end
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected self-termination");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_sum();
    test_bias_negative();
    test_saturation();
    test_backpressure();
    test_reset_mid_window();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/macc_accumulator.md
Name: macc_accumulator

Overview:
- Accumulation stage directly downstream of the pipelined radix-4 Booth multiplier in the MACC datapath.
- Consumes one signed product per beat and sums a configurable-length window of products plus a per-window bias. Typical window is 9 products for a 3x3 convolution kernel.
- Emits one saturated result per window through a registered valid/ready output.
- Applies backpressure upstream when the result register cannot be drained.

Parameters:
- PROD_W, 15, signed product width; matches the multiplier output.
- ACC_W, 24, signed accumulator and result width.
- LEN_W, 8, width of the window-length field; max window is 2^LEN_W-1 products.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset; synchronous, active-high.
- cfg_len  input  LEN_W  products per window; sampled on the first accepted beat of a window.
- cfg_bias  input  ACC_W  signed start value; sampled on the first accepted beat of a window.
- in_valid  input  1  in_prod valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_prod  input  PROD_W  signed product.
- out_valid  output  1  out_acc/out_sat hold a finished window result.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  signed, saturated window sum.
- out_sat  output  1  saturation occurred at any step of this window.
- busy  output  1  high while a window is open (state ACCUM).

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears state to IDLE.
  - acc=0, cnt=0, len_q=0, sat_q=0.
  - out_valid=0, out_acc=0, out_sat=0, busy=0.
  - A partial window is discarded. Reset dominates every other event in the same cycle.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - A beat is accepted when in_valid & in_ready.
  - No beat is lost or duplicated.
  - in_prod is not sampled when not accepted.
- States:
  - IDLE: no window open.
  - ACCUM: cnt products accepted, window incomplete.
- First beat of a window, accepted in IDLE:
  - len_q <= (cfg_len==0 ? 1 : cfg_len).
  - Start sum = sext(cfg_bias) + sext(in_prod).
  - cfg_len/cfg_bias changes while in ACCUM are ignored.
- Subsequent beat: sum = acc + sext(in_prod).
- Arithmetic:
  - sum is formed at ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, clamp to max; if sum < -2^(ACC_W-1), clamp to min.
  - Any clamp sets the window-sticky sat flag.
  - A saturated intermediate is the value carried forward; no wrap.
  - sat is cleared at window start, before that beat's own clamp is evaluated.
- Completion: the beat where accepted count reaches len_q.
  - Next edge: out_acc <= clamped sum, out_sat <= sticky sat including this beat, out_valid <= 1.
  - cnt <= 0, state <= IDLE.
  - acc is not needed afterwards; the next window reloads it.
- Not complete: acc <= clamped sum, cnt <= cnt+1, state <= ACCUM.
- Latency: result is visible on the cycle after the last product is accepted.
- Throughput: one product per cycle sustained while out_ready=1. Back-to-back windows need no bubble, including len=1 windows producing one result per cycle.
- Output register:
  - out_valid stays 1, and out_acc/out_sat stay stable, until out_valid & out_ready.
  - On a handshake with no new completion: out_valid <= 0.
  - Handshake and new completion in the same cycle: new result loads, out_valid stays 1.
- Stalls:
  - If out_valid=1 and out_ready=0, in_ready=0.
  - acc, cnt and state are frozen, mid-window or not.
- busy = (state==ACCUM).

Test Plan:
1. cfg_len=9, cfg_bias=0, products 1..9 on consecutive cycles, out_ready=1 -> out_acc=45 and out_sat=0, out_valid for exactly one cycle, one cycle after the 9th beat. busy high for cycles 2..9 of the window.
2. cfg_len=3, cfg_bias=100, products -16384, -1, 5 -> out_acc=-16280, out_sat=0.
3. cfg_len=2, cfg_bias=8388592, products 16383 then -1 -> first step clamps to 8388607; out_acc=8388606, out_sat=1. The next window with bias=0, len=1, product 7 -> out_acc=7, out_sat=0.
4. cfg_len=1, out_ready=0, products 10, 20, 30 offered continuously -> out_acc=10 holds; in_ready=0 after the first result. Releasing out_ready yields 20 then 30 in order with no loss or duplication. cfg_len=0 behaves identically to cfg_len=1.
5. cfg_len=4, three products accepted, rst=1 for one cycle -> all outputs 0. Then len=2 with products 3, 4 -> out_acc=7; the stale partial sum is not included.
6. cfg_len=3, product stream with random in_valid gaps and random out_ready -> results match a reference model beat for beat. A cfg_len change mid-window does not alter the window length.
